seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with a double-buffered value and a guard blank before each digit.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 is always shown).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    transfer;

    logic                    load_ack_q, load_ack_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
    logic                    frame_q, frame_d;

    logic [3:0]              digit [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi]  = active_d[4*gi +: 4];
            assign en_n_d[gi] = !(state_d == ST_SHOW && idx_d == IW'(gi));
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // zero_above[i] is set when digit i and every more significant digit are zero.
    logic [NUM_DIGITS-1:0] zero_above;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_above[gi] = (digit[gi] == 4'h0);
            end else begin : g_mid
                assign zero_above[gi] = (digit[gi] == 4'h0) && zero_above[gi+1];
            end
        end
    endgenerate
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            bcd_q      <= 4'hF;
            en_n_q     <= '1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            bcd_q      <= bcd_d;
            en_n_q     <= en_n_d;
            frame_q    <= frame_d;
        end
    end

    // The state registers describe the scan position currently on the outputs;
    // outputs are registered from the next position so they line up with it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        run_d     = enable;
        transfer  = 1'b0;

        if (!enable || !run_q) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == REFRESH_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            transfer = pending_q;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        active_d  = transfer ? shadow_q : active_q;
        shadow_d  = shadow_q;
        pending_d = transfer ? 1'b0 : pending_q;
        if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end

        load_ack_d = transfer;
        frame_d    = enable && run_q ? (state_d == ST_BLANK && idx_d == '0 && cnt_d == '0)
                                     : enable;
        bcd_d      = 4'hF;
        if (state_d == ST_SHOW) begin
            bcd_d = digit[idx_d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (idx_d != '0 && zero_above[idx_d]) begin
                bcd_d = 4'hF;
            end
`endif
        end
    end

    assign load_ack    = load_ack_q;
    assign bcd_out     = bcd_q;
    assign digit_en_n  = en_n_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (40-cycle frame).
module tb_seg_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    int          checks = 0;
    int          passes = 0;
    int          pos = 0;
    logic [15:0] val = 16'h0000;
    logic [15:0] val_next = 16'h0000;
    logic        ack_next = 1'b0;
    logic        exp_ack = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .load_ack   (load_ack),
        .bcd_out    (bcd_out),
        .digit_en_n (digit_en_n),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] exp_en(input int p);
        logic [3:0] m;
        m = 4'b0001 << (p / 10);
        return ((p % 10) < 2) ? 4'hF : ~m;
    endfunction

    function automatic logic [3:0] exp_bcd(input int p, input logic [15:0] v);
        int d;
        d = p / 10;
        if ((p % 10) < 2) return 4'hF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) return 4'hF;
`endif
        return v[4*d +: 4];
    endfunction

    task automatic check_pos();
        chk($sformatf("en p%0d", pos), {12'h0, digit_en_n}, {12'h0, exp_en(pos)});
        chk($sformatf("bcd p%0d v%0h", pos, val), {12'h0, bcd_out}, {12'h0, exp_bcd(pos, val)});
        chk($sformatf("frame p%0d", pos), {15'h0, frame_start}, {15'h0, (pos == 0)});
        chk($sformatf("ack p%0d", pos), {15'h0, load_ack}, {15'h0, exp_ack});
    endtask

    task automatic step();
        tick();
        pos = (pos + 1) % 40;
        exp_ack = 1'b0;
        if (pos == 0 && ack_next) begin
            exp_ack  = 1'b1;
            val      = val_next;
            ack_next = 1'b0;
        end
        check_pos();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 40 && pos != target; i++) step();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " en"}, {12'h0, digit_en_n}, 16'h000F);
        chk({tag, " bcd"}, {12'h0, bcd_out}, 16'h000F);
        chk({tag, " frame"}, {15'h0, frame_start}, 16'h0000);
        chk({tag, " ack"}, {15'h0, load_ack}, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; value_in = 16'h0;
        tick(); tick();
        check_idle("reset");

        // Start scanning: frame_start appears the cycle after enable is first sampled.
        reset = 1'b0; enable = 1'b1;
        tick(); pos = 0; exp_ack = 1'b0; check_pos();

        // Mid-frame load: current frame keeps 0000, 1234 appears next frame.
        run_to(15); load = 1'b1; value_in = 16'h1234; step(); load = 1'b0;
        ack_next = 1'b1; val_next = 16'h1234;
        run_to(39); step();

        // 1234 pending again, then 5678 loaded exactly in the transfer cycle.
        run_to(5); load = 1'b1; value_in = 16'h1234; step(); load = 1'b0;
        run_to(39); load = 1'b1; value_in = 16'h5678;
        ack_next = 1'b1; val_next = 16'h1234;
        step(); load = 1'b0;
        ack_next = 1'b1; val_next = 16'h5678;
        run_to(39); step();

        // Leading-zero behaviour on 0070.
        run_to(20); load = 1'b1; value_in = 16'h0070; step(); load = 1'b0;
        ack_next = 1'b1; val_next = 16'h0070;
        run_to(39); step();
        run_to(39); step();

        // Drop enable in SHOW of digit 2; loads still land while disabled.
        run_to(25); enable = 1'b0; tick(); check_idle("dis1");
        load = 1'b1; value_in = 16'h4321; tick(); load = 1'b0;
        tick(); tick(); check_idle("dis2");
        enable = 1'b1; tick(); pos = 0; exp_ack = 1'b0; check_pos();
        ack_next = 1'b1; val_next = 16'h4321;
        run_to(39); step();

        // Reset in SHOW of digit 1 with a pending value: value is discarded.
        run_to(8); load = 1'b1; value_in = 16'h8888; step(); load = 1'b0;
        run_to(15); reset = 1'b1; tick(); check_idle("rst2");
        reset = 1'b0; tick(); pos = 0; val = 16'h0000; exp_ack = 1'b0; check_pos();
        run_to(39); step();
        run_to(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
